mips32_prog_loader: RTL and testbench

- Upstream feeder for pipe_MIPS32: receives a byte-serial program/data image and writes it as 32-bit words into the core's unified memory.
- Keeps the core held while loading, then releases it with a one-cycle start pulse.
- Replaces hierarchical Mem/PC/HALTED pokes with a real load path usable from a UART/host byte stream.

---
 rtl/mips32_pkg.sv | 12 +
 rtl/mips32_byte_packer.sv | 24 ++
 rtl/mips32_prog_loader.sv | 116 +++++++++++
 tb/tb_mips32_prog_loader.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared state encoding and frame constants for the pipe_MIPS32 program loader.
package mips32_pkg;
  localparam int WORD_W = 32;
  localparam int HDR_ADDR_BYTES = 4;
  localparam int HDR_CNT_BYTES = 2;
  typedef logic [2:0] state_t;
  localparam state_t HDR_ADDR = 3'd0;
  localparam state_t HDR_CNT = 3'd1;
  localparam state_t DATA = 3'd2;
  localparam state_t CKSUM = 3'd3;
  localparam state_t START = 3'd4;
endpackage

// File: rtl/mips32_byte_packer.sv
// mips32_byte_packer: big-endian byte-to-word shift register; word_done marks the 4th byte, word is valid with it.
module mips32_byte_packer
  import mips32_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  input  logic              en,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);
  logic [1:0] cnt;
  logic [WORD_W-9:0] sh;
  assign word = {sh, din};
  assign word_done = en && cnt == 2'd3;
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      cnt <= 2'd0;
      sh <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sh <= word[WORD_W-9:0];
    end
endmodule

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: loads a byte-serial framed image into pipe_MIPS32 memory, then releases the core.
// Define LOADER_CKSUM_EN to require an XOR trailer byte per frame.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_run,
  output logic              core_start,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  words_loaded
);
  state_t state, state_n;
  logic [1:0] bcnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0] n_q, n_new;
  logic [WORD_W-1:0] pk_word;
  logic fire, first, pk_done, last, stall;
  assign fire = s_valid && s_ready;
  assign first = fire && state == HDR_ADDR && bcnt == 2'd0;
  assign n_new = CNT_W'({n_q, s_data});
  assign last = pk_done && words_loaded + CNT_W'(1) == n_q;
  mips32_byte_packer u_packer (
    .clk1(clk1),
    .rst(rst),
    .en(fire && state == DATA),
    .din(s_data),
    .word(pk_word),
    .word_done(pk_done)
  );
`ifdef LOADER_CKSUM_EN
  localparam state_t TAIL = CKSUM;
  logic [7:0] cks;
  logic err_q;
  assign stall = 1'b0;
  assign err = err_q;
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      cks <= 8'd0;
      err_q <= 1'b0;
    end else if (fire) begin
      cks <= first ? s_data : cks ^ s_data;
      err_q <= first ? 1'b0 : err_q | (state == CKSUM && s_data != cks);
    end
`else
  localparam state_t TAIL = START;
  // hold off one cycle after the last word so its write never overlaps core_start
  assign stall = last;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk1 or posedge rst)
    if (rst) state <= HDR_ADDR;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      HDR_ADDR: if (fire && bcnt == 2'(HDR_ADDR_BYTES - 1)) state_n = HDR_CNT;
      HDR_CNT: if (fire && bcnt == 2'(HDR_CNT_BYTES - 1)) state_n = n_new == '0 ? TAIL : DATA;
`ifdef LOADER_CKSUM_EN
      DATA: if (last) state_n = CKSUM;
      CKSUM: if (fire) state_n = s_data == cks ? START : HDR_ADDR;
`else
      DATA: if (mem_we && words_loaded == n_q) state_n = START;
`endif
      default: state_n = HDR_ADDR;
    endcase
  end
  always_comb core_start = state == START;
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      bcnt <= 2'd0;
      cur_addr <= '0;
      n_q <= '0;
      s_ready <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      core_run <= 1'b0;
      busy <= 1'b0;
      words_loaded <= '0;
    end else begin
      s_ready <= state_n != START && !stall;
      mem_we <= pk_done;
      if (fire && (state == HDR_ADDR || state == HDR_CNT)) bcnt <= state_n != state ? 2'd0 : bcnt + 2'd1;
      if (fire && state == HDR_ADDR) cur_addr <= ADDR_W'({cur_addr, s_data});
      if (fire && state == HDR_CNT) n_q <= n_new;
      if (pk_done) begin
        mem_addr <= cur_addr;
        mem_wdata <= pk_word;
        cur_addr <= cur_addr + ADDR_W'(1);
        words_loaded <= words_loaded + CNT_W'(1);
      end
      if (first) begin
        busy <= 1'b1;
        core_run <= 1'b0;
        words_loaded <= '0;
      end
      if (state_n == START) begin
        busy <= 1'b0;
        core_run <= 1'b1;
      end
`ifdef LOADER_CKSUM_EN
      if (fire && state == CKSUM && s_data != cks) busy <= 1'b0;
`endif
    end
endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: table-driven and randomized frames checked against a queue-based write model.
module tb_mips32_prog_loader;
  localparam int AW = 10;
  typedef struct packed {
    logic [31:0] base;
    logic [15:0] n;
    logic [11:0][31:0] w;
    logic [15:0] exp_wl;
    logic [AW-1:0] exp_last;
  } frame_t;
  logic clk1 = 1'b0, rst = 1'b1, s_valid = 1'b0, gap = 1'b0;
  logic [7:0] s_data = 8'd0, x_cks;
  logic s_ready, mem_we, core_run, core_start, busy, err;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_loaded;
  int errors = 0, checks = 0, starts = 0;
  logic [AW+31:0] wq[$];
  frame_t tbl[4];
  frame_t f;
  mips32_prog_loader #(.ADDR_W(AW), .CNT_W(16)) dut (
    .clk1(clk1), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_run(core_run),
    .core_start(core_start), .busy(busy), .err(err), .words_loaded(words_loaded)
  );
  always #5 clk1 = ~clk1;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  always @(negedge clk1) if (!rst) begin
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (core_start) starts++;
    chk("we_start_overlap", {63'd0, mem_we & core_start}, 64'd0);
    chk("run_while_busy", {63'd0, busy & core_run}, 64'd0);
  end
  task automatic put(input logic [7:0] b);
    if (gap) while ($urandom_range(0, 1) == 1) @(negedge clk1);
    s_data = b;
    s_valid = 1'b1;
    x_cks ^= b;
    for (int g = 0; g < 40 && !s_ready; g++) @(negedge clk1);
    chk("ready_wait", {63'd0, s_ready}, 64'd1);
    @(posedge clk1);
    @(negedge clk1);
    s_valid = 1'b0;
  endtask
  task automatic send_hdr(input frame_t fr);
    x_cks = 8'd0;
    for (int k = 3; k >= 0; k--) put(fr.base[8*k+:8]);
    put(fr.n[15:8]);
    put(fr.n[7:0]);
  endtask
  task automatic send_frame(input frame_t fr, input logic corrupt);
    send_hdr(fr);
    for (int i = 0; i < int'(fr.n); i++)
      for (int k = 3; k >= 0; k--) put(fr.w[i][8*k+:8]);
`ifdef LOADER_CKSUM_EN
    put(x_cks ^ {7'd0, corrupt});
`else
    if (corrupt) chk("corrupt_unsupported", 64'd1, 64'd0);
`endif
  endtask
  task automatic run_frame(input frame_t fr, input string tag);
    int s0;
    logic [31:0] a;
    wq.delete();
    s0 = starts;
    send_frame(fr, 1'b0);
    for (int g = 0; g < 40 && starts == s0; g++) @(negedge clk1);
    repeat (4) @(negedge clk1);
    chk({tag, "_starts"}, 64'(starts - s0), 64'd1);
    chk({tag, "_nwrites"}, 64'(wq.size()), 64'(fr.n));
    for (int i = 0; i < int'(fr.n) && i < wq.size(); i++) begin
      a = fr.base + 32'(i);
      chk({tag, "_write"}, 64'(wq[i]), 64'({a[AW-1:0], fr.w[i]}));
    end
    chk({tag, "_status"}, {words_loaded, core_run, busy, err}, {fr.exp_wl, 3'b100});
    if (fr.n != 16'd0) chk({tag, "_last_addr"}, 64'(mem_addr), 64'(fr.exp_last));
  endtask
  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '0;
    tbl[0].n = 16'd11;
    tbl[0].w[0] = 32'h280a00c8; tbl[0].w[1] = 32'h28020001; tbl[0].w[2] = 32'h0e94a000;
    tbl[0].w[3] = 32'h21430000; tbl[0].w[4] = 32'h0e94a000; tbl[0].w[5] = 32'h14431000;
    tbl[0].w[6] = 32'h2c630001; tbl[0].w[7] = 32'h0e94a000; tbl[0].w[8] = 32'h3460fffc;
    tbl[0].w[9] = 32'h2542fffe; tbl[0].w[10] = 32'hfc000000;
    tbl[0].exp_wl = 16'd11; tbl[0].exp_last = 10'd10;
    tbl[1] = '0; tbl[1].base = 32'd200; tbl[1].n = 16'd1; tbl[1].w[0] = 32'h7;
    tbl[1].exp_wl = 16'd1; tbl[1].exp_last = 10'd200;
    tbl[2] = '0; tbl[2].base = 32'd5;
    tbl[3] = '0; tbl[3].base = 32'h3ff; tbl[3].n = 16'd2;
    tbl[3].w[0] = 32'haaaa5555; tbl[3].w[1] = 32'h12345678;
    tbl[3].exp_wl = 16'd2; tbl[3].exp_last = 10'd0;
    #1;
    chk("reset_outputs", {s_ready, mem_we, core_run, core_start, busy, err, words_loaded, mem_addr, mem_wdata}, 64'd0);
    repeat (3) @(negedge clk1);
    rst = 1'b0;
    #1 chk("ready_low_after_reset", {63'd0, s_ready}, 64'd0);
    @(negedge clk1);
    chk("ready_rises", {63'd0, s_ready}, 64'd1);
    for (int t = 0; t < 4; t++) run_frame(tbl[t], $sformatf("tbl%0d", t));
    wq.delete();
    send_hdr(tbl[2]);
`ifdef LOADER_CKSUM_EN
    put(x_cks);
`endif
    chk("zero_start_now", {62'd0, core_start, mem_we}, 64'd2);
    @(negedge clk1);
    chk("zero_start_once", {62'd0, core_start, s_ready}, 64'd1);
    chk("zero_no_write", 64'(wq.size()), 64'd0);
    gap = 1'b1;
    run_frame(tbl[0], "gappy_fact");
    for (int r = 0; r < 4; r++) begin
      f = '0;
      f.base = $urandom;
      f.n = 16'($urandom_range(1, 12));
      for (int i = 0; i < 12; i++) f.w[i] = $urandom;
      f.exp_wl = f.n;
      f.exp_last = f.base[AW-1:0] + AW'(f.n - 16'd1);
      run_frame(f, $sformatf("rand%0d", r));
    end
    gap = 1'b0;
`ifdef LOADER_CKSUM_EN
    begin
      int s0;
      s0 = starts;
      send_frame(tbl[3], 1'b1);
      repeat (5) @(negedge clk1);
      chk("bad_cks", {32'(starts - s0), 29'd0, err, core_run, busy}, {32'd0, 32'd4});
      run_frame(tbl[1], "after_bad_cks");
    end
`endif
    wq.delete();
    send_hdr(tbl[0]);
    for (int i = 0; i < 2; i++)
      for (int k = 3; k >= 0; k--) put(tbl[0].w[i][8*k+:8]);
    put(tbl[0].w[2][31:24]);
    put(tbl[0].w[2][23:16]);
    #1 rst = 1'b1;
    #1 chk("midreset_outputs", {s_ready, mem_we, core_run, core_start, busy, err, words_loaded, mem_addr, mem_wdata}, 64'd0);
    @(negedge clk1);
    rst = 1'b0;
    repeat (3) @(negedge clk1);
    chk("midreset_writes", 64'(wq.size()), 64'd2);
    chk("midreset_ready", {62'd0, s_ready, core_run}, 64'd2);
    run_frame(tbl[0], "after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
